// File: rtl/line_mem_if.sv
// Cache miss-path request/grant bundle between the cache (master) and the
// line memory (slave).
interface line_mem_if #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int ADDR_LEN      = 9
);
  localparam int LINE_W = 32 << LINE_ADDR_LEN;

  // Handshake: the master raises rd_req and/or wr_req as a level and holds it
  // with addr/wr_line until gnt, a one-cycle pulse from the slave. Dropping
  // both requests before gnt aborts the transaction. Requests still high
  // during the gnt cycle belong to the finished transaction and are ignored.
  logic [ADDR_LEN-1:0] addr;
  logic                rd_req;
  logic                wr_req;
  logic [LINE_W-1:0]   wr_line;
  logic                gnt;
  logic [LINE_W-1:0]   rd_line;
  logic [31:0]         rd_cnt;
  logic [31:0]         wr_cnt;

  modport master (
    output addr, rd_req, wr_req, wr_line,
    input  gnt, rd_line, rd_cnt, wr_cnt
  );

  modport slave (
    input  addr, rd_req, wr_req, wr_line,
    output gnt, rd_line, rd_cnt, wr_cnt
  );
endinterface

// File: rtl/line_mem_responder.sv
// Line-granular main-memory responder with a fixed access latency.
// Define LINE_MEM_STATS_EN to enable the rd_cnt/wr_cnt commit counters.
module line_mem_responder #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int ADDR_LEN      = 9,
  parameter int LATENCY       = 8
) (
  input  logic       clk,
  input  logic       rst,
  line_mem_if.slave  bus,
  output logic [1:0] dbg_state
);
  localparam int          LINE_W   = 32 << LINE_ADDR_LEN;
  localparam int          DEPTH    = 1 << ADDR_LEN;
  localparam logic [7:0]  CNT_INIT = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GNT  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [ADDR_LEN-1:0] addr_q, addr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic [LINE_W-1:0]   rd_line_q, rd_line_d;
  logic                is_rd_q, is_rd_d;
  logic                is_wr_q, is_wr_d;
  logic                commit;
  logic                mem_we;

  // Storage powers up zeroed and is deliberately untouched by rst.
  logic [LINE_W-1:0] mem [DEPTH] = '{default: '0};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    is_rd_d   = is_rd_q;
    is_wr_d   = is_wr_q;
    rd_line_d = rd_line_q;
    commit    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.rd_req | bus.wr_req) begin
          addr_d  = bus.addr;
          wdata_d = bus.wr_line;
          is_rd_d = bus.rd_req;
          is_wr_d = bus.wr_req;
          cnt_d   = CNT_INIT;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!(bus.rd_req | bus.wr_req)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          commit  = 1'b1;
          state_d = GNT;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      GNT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A combined read+write returns the line being written, not the old one.
    if (commit && is_rd_q) begin
      rd_line_d = is_wr_q ? wdata_q : mem[addr_q];
    end
  end

  assign mem_we = commit & is_wr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      is_rd_q   <= 1'b0;
      is_wr_q   <= 1'b0;
      rd_line_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      is_rd_q   <= is_rd_d;
      is_wr_q   <= is_wr_d;
      rd_line_q <= rd_line_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[addr_q] <= wdata_q;
    end
  end

`ifdef LINE_MEM_STATS_EN
  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;

  always_comb begin
    rd_cnt_d = rd_cnt_q + 32'(commit & is_rd_q);
    wr_cnt_d = wr_cnt_q + 32'(commit & is_wr_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign bus.rd_cnt = rd_cnt_q;
  assign bus.wr_cnt = wr_cnt_q;
`else
  assign bus.rd_cnt = '0;
  assign bus.wr_cnt = '0;
`endif

  assign bus.gnt     = (state_q == GNT);
  assign bus.rd_line = rd_line_q;
  assign dbg_state   = state_q;
endmodule

// File: tb/tb_line_mem_responder.sv
// Directed bench for line_mem_responder: latency, read/write data, back-to-back,
// abort, reset mid-transaction and combined read+write.
module tb_line_mem_responder;
  localparam int LA  = 3;
  localparam int AL  = 9;
  localparam int LAT = 8;
  localparam int LW  = 32 << LA;
`ifdef LINE_MEM_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;
  int         vectors = 0;
  int         miscompares = 0;

  line_mem_if #(.LINE_ADDR_LEN(LA), .ADDR_LEN(AL)) bus ();

  line_mem_responder #(.LINE_ADDR_LEN(LA), .ADDR_LEN(AL), .LATENCY(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] mk_line(input logic [31:0] base);
    logic [LW-1:0] l;
    l = '0;
    for (int i = 0; i < (1 << LA); i++) l[i*32 +: 32] = base + 32'(i);
    return l;
  endfunction

  function automatic logic [31:0] exp_cnt(input int k);
    return STATS ? 32'(k) : 32'd0;
  endfunction

  // driver: called at a negedge; returns negedges until gnt (-1 on timeout)
  task automatic txn(input logic [AL-1:0] a, input logic r, input logic w,
                     input logic [LW-1:0] d, input bit scramble, output int n);
    bus.addr    = a;
    bus.rd_req  = r;
    bus.wr_req  = w;
    bus.wr_line = d;
    n = -1;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (scramble && i == 1) begin
        bus.addr    = '0;
        bus.wr_line = '1;
      end
      if (bus.gnt === 1'b1) begin
        n = i;
        break;
      end
    end
    bus.rd_req = 1'b0;
    bus.wr_req = 1'b0;
  endtask

  task automatic count_gnt(input int cycles, output int hits);
    hits = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.gnt === 1'b1) hits++;
    end
  endtask

  initial begin
    int n;
    int hits;
    bus.addr    = '0;
    bus.rd_req  = 1'b0;
    bus.wr_req  = 1'b0;
    bus.wr_line = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_gnt", LW'(bus.gnt), '0);
    check("rst_rd_line", bus.rd_line, '0);
    check("rst_rd_cnt", LW'(bus.rd_cnt), '0);
    check("rst_wr_cnt", LW'(bus.wr_cnt), '0);
    check("rst_state", LW'(dbg_state), LW'(0));
    rst = 1'b0;
    @(negedge clk);

    // read of never-written line: gnt LAT edges after acceptance, zeros
    txn(9'd5, 1'b1, 1'b0, '0, 1'b0, n);
    check("rd5_latency", LW'(n), LW'(LAT + 1));
    check("rd5_data", bus.rd_line, '0);
    @(negedge clk);
    check("rd5_gnt_single", LW'(bus.gnt), '0);
    check("rd5_state_idle", LW'(dbg_state), LW'(0));

    // write 0x1A3 (addr/data changed after acceptance), then read it back
    txn(9'h1A3, 1'b0, 1'b1, mk_line(32'h100), 1'b1, n);
    check("wr1a3_latency", LW'(n), LW'(LAT + 1));
    check("wr1a3_rd_line_kept", bus.rd_line, '0);
    @(negedge clk);
    txn(9'h1A3, 1'b1, 1'b0, '0, 1'b0, n);
    check("rd1a3_latency", LW'(n), LW'(LAT + 1));
    check("rd1a3_data", bus.rd_line, mk_line(32'h100));
    @(negedge clk);
    check("rd1a3_data_stable", bus.rd_line, mk_line(32'h100));
    check("cnt_rd_2", LW'(bus.rd_cnt), LW'(exp_cnt(2)));
    check("cnt_wr_1", LW'(bus.wr_cnt), LW'(exp_cnt(1)));

    // back-to-back: read of 11 raised in the gnt cycle of the write to 3,
    // accepted in the idle cycle after; gnts LAT+2 edges apart
    txn(9'd3, 1'b0, 1'b1, mk_line(32'h300), 1'b0, n);
    check("b2b_wr_latency", LW'(n), LW'(LAT + 1));
    txn(9'd11, 1'b1, 1'b0, '0, 1'b0, n);
    check("b2b_gnt_gap", LW'(n), LW'(LAT + 2));
    check("b2b_rd11_data", bus.rd_line, '0);
    @(negedge clk);
    txn(9'd3, 1'b1, 1'b0, '0, 1'b0, n);
    check("rd3_data", bus.rd_line, mk_line(32'h300));
    @(negedge clk);

    // abort at BUSY count 4, then full restart
    bus.addr   = 9'h1A3;
    bus.rd_req = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_state_busy", LW'(dbg_state), LW'(1));
    bus.rd_req = 1'b0;
    count_gnt(15, hits);
    check("abort_no_gnt", LW'(hits), '0);
    check("abort_state_idle", LW'(dbg_state), LW'(0));
    check("abort_rd_line_kept", bus.rd_line, mk_line(32'h300));
    txn(9'h1A3, 1'b1, 1'b0, '0, 1'b0, n);
    check("restart_latency", LW'(n), LW'(LAT + 1));
    check("restart_data", bus.rd_line, mk_line(32'h100));
    @(negedge clk);
    check("cnt_rd_5", LW'(bus.rd_cnt), LW'(exp_cnt(5)));
    check("cnt_wr_2", LW'(bus.wr_cnt), LW'(exp_cnt(2)));

    // reset during BUSY of a write to 7
    bus.addr    = 9'd7;
    bus.wr_line = mk_line(32'h700);
    bus.wr_req  = 1'b1;
    repeat (3) @(negedge clk);
    check("midwr_state_busy", LW'(dbg_state), LW'(1));
    rst = 1'b1;
    #1;
    check("midwr_rst_state", LW'(dbg_state), LW'(0));
    check("midwr_rst_gnt", LW'(bus.gnt), '0);
    check("midwr_rst_rd_line", bus.rd_line, '0);
    check("midwr_rst_rd_cnt", LW'(bus.rd_cnt), '0);
    check("midwr_rst_wr_cnt", LW'(bus.wr_cnt), '0);
    bus.wr_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    count_gnt(12, hits);
    check("midwr_no_gnt", LW'(hits), '0);
    txn(9'd7, 1'b1, 1'b0, '0, 1'b0, n);
    check("rd7_latency", LW'(n), LW'(LAT + 1));
    check("rd7_old_data", bus.rd_line, '0);
    @(negedge clk);

    // simultaneous read+write to 2
    txn(9'd2, 1'b1, 1'b1, mk_line(32'hDEAD_0000), 1'b0, n);
    check("rw2_latency", LW'(n), LW'(LAT + 1));
    check("rw2_data", bus.rd_line, mk_line(32'hDEAD_0000));
    count_gnt(LAT + 4, hits);
    check("rw2_single_gnt", LW'(hits), '0);
    check("cnt_rd_after_rw", LW'(bus.rd_cnt), LW'(exp_cnt(2)));
    check("cnt_wr_after_rw", LW'(bus.wr_cnt), LW'(exp_cnt(1)));
    txn(9'd3, 1'b1, 1'b0, '0, 1'b0, n);
    check("rd3_survives_rst", bus.rd_line, mk_line(32'h300));
    @(negedge clk);
    txn(9'd2, 1'b1, 1'b0, '0, 1'b0, n);
    check("rd2_stored", bus.rd_line, mk_line(32'hDEAD_0000));
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
